// File: rtl/store_buffer_if.sv
// store_buffer_if: execute-stage store/load requests and data-memory port driven by store_buffer.
interface store_buffer_if #(parameter int AW = 5, parameter int DW = 32);
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          ld_stall;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          empty;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr,
        input  st_ready, ld_hit, ld_data, ld_stall, mem_read, mem_write, mem_addr, mem_wdata, empty
    );
    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr,
        output st_ready, ld_hit, ld_data, ld_stall, mem_read, mem_write, mem_addr, mem_wdata, empty
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: posted-store FIFO draining in order to the single-port data memory; loads win the port.
// Define STORE_FWD_EN to forward the youngest matching store to loads instead of stalling them.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input logic           clk,
    input logic           rst_n,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head, tail, idx;
    logic [PW:0]   count;
    logic [1:0]    starve;
    logic          full, push, pop, rd, match, force_drain;
    logic [DW-1:0] match_data;

    // Scan oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        match = 1'b0;
        match_data = '0;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((PW+1)'(k) < count && addr_q[idx] == bus.ld_addr) begin
                match = 1'b1;
                match_data = data_q[idx];
            end
        end
    end

    assign full        = count == FULL_CNT;
    assign force_drain = full && bus.ld_valid && starve == 2'd2;
    assign bus.ld_hit   = FWD && bus.ld_valid && match;
    assign bus.ld_data  = bus.ld_hit ? match_data : '0;
    assign bus.ld_stall = bus.ld_valid && !bus.ld_hit && ((match && !FWD) || force_drain);

    assign rd   = rst_n && bus.ld_valid && !bus.ld_stall && !bus.ld_hit;
    assign pop  = !rd && count != '0;
    assign push = bus.st_valid && bus.st_ready;

    assign bus.st_ready  = !full;
    assign bus.empty     = count == '0;
    assign bus.mem_read  = rd;
    assign bus.mem_write = pop;
    assign bus.mem_addr  = rd ? bus.ld_addr : pop ? addr_q[head] : '0;
    assign bus.mem_wdata = pop ? data_q[head] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            starve <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count  <= count + (PW+1)'(push) - (PW+1)'(pop);
            starve <= (full && bus.ld_valid && !pop) ? starve + 2'd1 : 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= bus.st_addr;
            data_q[tail] <= bus.st_data;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and random stores/loads checked against a queue model and a memory image.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    ent_t pend[$];
    logic [DW-1:0] tmem [32];
    logic [DW-1:0] arch [32];
    int starve = 0;

    store_buffer_if #(.AW(AW), .DW(DW)) bus ();
    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
    endtask

    // One clock: drive, compare against the model mid-cycle, then advance model and memory image.
    task automatic cycle(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                         input logic lv, input logic [AW-1:0] la);
        bit found, full, hit, stall, rd, wr, push;
        logic [DW-1:0] fd;
        logic w_en;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_data;
        @(negedge clk);
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.ld_valid = lv;
        bus.ld_addr  = la;
        #1;
        full = pend.size() == DEPTH;
        found = 1'b0;
        fd = '0;
        foreach (pend[i]) if (pend[i].a == la) begin found = 1'b1; fd = pend[i].d; end
        hit   = FWD && lv && found;
        stall = lv && !hit && ((!FWD && found) || (full && starve >= 2));
        rd    = lv && !stall && !hit;
        wr    = !rd && pend.size() > 0;
        push  = sv && !full;
        chk("st_ready",  DW'(bus.st_ready),  DW'(!full));
        chk("empty",     DW'(bus.empty),     DW'(pend.size() == 0));
        chk("mem_read",  DW'(bus.mem_read),  DW'(rd));
        chk("mem_write", DW'(bus.mem_write), DW'(wr));
        chk("mem_addr",  DW'(bus.mem_addr),  DW'(rd ? la : wr ? pend[0].a : '0));
        chk("mem_wdata", bus.mem_wdata,      wr ? pend[0].d : '0);
        chk("ld_hit",    DW'(bus.ld_hit),    DW'(hit));
        chk("ld_data",   bus.ld_data,        hit ? fd : '0);
        chk("ld_stall",  DW'(bus.ld_stall),  DW'(stall));
        if (lv && !stall) chk("ld_value", bus.ld_hit ? bus.ld_data : tmem[bus.mem_addr], arch[la]);
        w_en = bus.mem_write;
        w_addr = bus.mem_addr;
        w_data = bus.mem_wdata;
        @(posedge clk);
        if (w_en) tmem[w_addr] = w_data;
        if (wr) void'(pend.pop_front());
        if (push) begin
            pend.push_back('{a: sa, d: sd});
            arch[sa] = sd;
        end
        starve = (full && lv && !wr) ? starve + 1 : 0;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_st_ready",  DW'(bus.st_ready),  DW'(1));
        chk("rst_empty",     DW'(bus.empty),     DW'(1));
        chk("rst_mem_read",  DW'(bus.mem_read),  '0);
        chk("rst_mem_write", DW'(bus.mem_write), '0);
        chk("rst_mem_addr",  DW'(bus.mem_addr),  '0);
        chk("rst_mem_wdata", bus.mem_wdata,      '0);
        chk("rst_ld_hit",    DW'(bus.ld_hit),    '0);
        chk("rst_ld_data",   bus.ld_data,        '0);
        chk("rst_ld_stall",  DW'(bus.ld_stall),  '0);
        @(negedge clk);
        rst_n = 1'b1;
        pend.delete();
        starve = 0;
        arch = tmem;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            tmem[i] = '0;
            arch[i] = '0;
        end
        idle_inputs();
        rst_pulse();
        repeat (2) cycle(1'b0, '0, '0, 1'b0, '0);
        // Back-to-back stores drain on the following cycles.
        cycle(1'b1, 5'd3, 32'd17, 1'b0, '0);
        cycle(1'b1, 5'd5, 32'd9, 1'b0, '0);
        repeat (3) cycle(1'b0, '0, '0, 1'b0, '0);
        // Overfill while a load holds the port; the starvation guard must kick in.
        for (int i = 0; i < 5; i++) cycle(1'b1, AW'(8 + i), $urandom, 1'b1, 5'd1);
        repeat (4) cycle(1'b0, '0, '0, 1'b1, 5'd1);
        repeat (5) cycle(1'b0, '0, '0, 1'b0, '0);
        // Duplicate address then a dependent load.
        cycle(1'b1, 5'd7, 32'd25, 1'b1, 5'd2);
        cycle(1'b1, 5'd7, 32'd40, 1'b1, 5'd2);
        repeat (4) cycle(1'b0, '0, '0, 1'b1, 5'd7);
        repeat (2) cycle(1'b0, '0, '0, 1'b0, '0);
        // Fill, then keep pushing while it drains.
        for (int i = 0; i < 4; i++) cycle(1'b1, AW'(16 + i), $urandom, 1'b1, 5'd30);
        for (int i = 0; i < 8; i++) cycle(1'b1, AW'(20 + i), $urandom, 1'b0, '0);
        repeat (5) cycle(1'b0, '0, '0, 1'b0, '0);
        // Reset with three stores pending; none of them may reach memory.
        for (int i = 0; i < 3; i++) cycle(1'b1, AW'(24 + i), $urandom, 1'b1, 5'd0);
        rst_pulse();
        repeat (4) cycle(1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(1, 0)), AW'($urandom_range(7, 0)), $urandom,
                  1'($urandom_range(2, 0) != 0), AW'($urandom_range(7, 0)));
        repeat (6) cycle(1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, '0, 1'b1, AW'(i));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
